// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, column codes and helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [3:0] COL0      = 4'b1110;
    localparam logic [3:0] COL1      = 4'b1101;
    localparam logic [3:0] COL2      = 4'b1011;
    localparam logic [3:0] COL3      = 4'b0111;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam int         KEY_W     = 4;

    function automatic logic one_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Index of the lowest zero bit; only meaningful when exactly one bit is low.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 4-bit two-flop synchronizer, resets to all-high (idle active-low inputs)
module sync_2ff (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// rtl/keypad_scan_decoder.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int PS_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CNT);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

    logic [3:0] row_s;

    sync_2ff u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (row),
        .d_out (row_s)
    );

    state_t           state_q, state_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic [DB_W-1:0]  deb_q, deb_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       row_cap_q, row_cap_d;
    logic [KEY_W-1:0] cap_code_q, cap_code_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic scan_tick, row_hit, cap_match, rows_idle, deb_done;

    assign scan_tick = (prescale_q == PS_LAST);
    assign row_hit   = one_low(row_s);
    assign cap_match = (row_s == row_cap_q);
    assign rows_idle = (row_s == ROWS_IDLE);
    assign deb_done  = (deb_q == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            prescale_q  <= '0;
            deb_q       <= '0;
            col_q       <= COL0;
            row_cap_q   <= ROWS_IDLE;
            cap_code_q  <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescale_q  <= prescale_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            row_cap_q   <= row_cap_d;
            cap_code_q  <= cap_code_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:     if (scan_tick && row_hit) state_d = DEBOUNCE;
            DEBOUNCE: if (!cap_match) state_d = SCAN;
                      else if (deb_done) state_d = PRESSED;
            PRESSED:  if (rows_idle) state_d = RELEASE;
            RELEASE:  if (!rows_idle) state_d = PRESSED;
                      else if (deb_done) state_d = SCAN;
            default:  state_d = SCAN;
        endcase
    end

    always_comb begin
        prescale_d  = prescale_q;
        deb_d       = deb_q;
        col_d       = col_q;
        row_cap_d   = row_cap_q;
        cap_code_d  = cap_code_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                prescale_d = scan_tick ? '0 : prescale_q + 1'b1;
                if (scan_tick) begin
                    if (row_hit) begin
                        row_cap_d  = row_s;
                        cap_code_d = {low_idx(row_s), low_idx(col_q)};
                    end else begin
                        col_d = next_col(col_q);
                    end
                end
            end
            DEBOUNCE: begin
                if (!cap_match) begin
                    col_d = next_col(col_q);
                end else if (deb_done) begin
                    key_code_d  = cap_code_q;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            RELEASE: begin
                if (rows_idle) begin
                    if (deb_done) begin
                        key_held_d = 1'b0;
                        col_d      = next_col(col_q);
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Every state change restarts both counters, so SCAN re-entry begins a fresh strobe.
        if (state_d != state_q) begin
            deb_d      = '0;
            prescale_d = '0;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb/tb_keypad_scan_decoder.sv - scoreboard bench for keypad_scan_decoder
module tb_keypad_scan_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic       key_down;
    logic [1:0] key_r;
    logic [1:0] key_c;
    logic       ovr_en;
    logic [3:0] ovr_val;

    logic [3:0] exp_q[$];
    int         checks;
    int         errors;

    keypad_scan_decoder #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a held key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'b1111;
        if (key_down && !col[key_c]) row[key_r] = 1'b0;
        if (ovr_en) row = ovr_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic       prev_v;
        logic [3:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual_code=%b required=no pulse", key_code);
                end else begin
                    e = exp_q.pop_front();
                    check("key_code", key_code, e);
                    check("held_with_valid", key_held, 1);
                end
                check("valid_single_cycle", prev_v, 0);
            end
            prev_v = key_valid;
        end
    endtask

    task automatic wait_col_first(input logic [3:0] v);
        int n;
        n = 0;
        while (col == v && n < 64) begin @(negedge clk); n++; end
        while (col != v && n < 64) begin @(negedge clk); n++; end
        check("wait_col", col, v);
    endtask

    task automatic wait_held(input logic v);
        int n;
        n = 0;
        while (key_held !== v && n < 200) begin @(negedge clk); n++; end
        check("wait_held", key_held, v);
    endtask

    initial begin
        logic [3:0] sweep [4];
        sweep[0] = 4'b1110; sweep[1] = 4'b1101; sweep[2] = 4'b1011; sweep[3] = 4'b0111;
        checks = 0; errors = 0;
        key_down = 1'b0; key_r = 2'd2; key_c = 2'd1;
        ovr_en = 1'b0; ovr_val = 4'b1111;
        reset = 1'b1;
        fork monitor(); join_none

        // Asynchronous reset mid-scan
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_col", col, 4'b1101);
        #2 reset = 1'b1;
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);

        // Idle sweep
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("sweep_col", col, sweep[(k / 4) % 4]);
            @(negedge clk);
        end

        // Clean press row 2 / column 1
        exp_q.push_back(4'b1001);
        key_down = 1'b1;
        wait_held(1'b1);
        for (int k = 0; k < 6; k++) begin
            check("frozen_col", col, 4'b1101);
            @(negedge clk);
        end
        key_down = 1'b0;
        wait_held(1'b0);
        check("col_after_release", col, 4'b1011);

        // Press that bounces right after the scan sample
        key_down = 1'b1;
        wait_col_first(4'b1101);
        repeat (4) @(negedge clk);
        ovr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ovr_val = (i % 2 == 0) ? 4'b1111 : 4'b1011;
            @(negedge clk);
        end
        check("bounce_rescan_col", col, 4'b1011);
        check("bounce_held", key_held, 0);
        ovr_en = 1'b0;
        exp_q.push_back(4'b1001);
        wait_held(1'b1);

        // Release that bounces low after three high clocks
        key_down = 1'b0;
        repeat (3) @(negedge clk);
        key_down = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("release_bounce_held", key_held, 1);
        end
        key_down = 1'b0;
        wait_held(1'b0);

        // Ghosting during column 0
        wait_col_first(4'b1110);
        ovr_en = 1'b1;
        ovr_val = 4'b0011;
        repeat (4) @(negedge clk);
        check("ghost_col1", col, 4'b1101);
        repeat (4) @(negedge clk);
        check("ghost_col2", col, 4'b1011);
        ovr_en = 1'b0;

        // Reset while the debounce counter sits at 5
        wait_col_first(4'b1011);
        key_down = 1'b1;
        wait_col_first(4'b1101);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("dbrst_col", col, 4'b1110);
        check("dbrst_valid", key_valid, 0);
        check("dbrst_code", key_code, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(4'b1001);
        wait_held(1'b1);
        key_down = 1'b0;
        wait_held(1'b0);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
